// File: rtl/multi_key_debounce_pkg.sv
// rtl/multi_key_debounce_pkg.sv - shared timing constants and per-channel output bundle
package multi_key_debounce_pkg;

  // Default timing for a 50 MHz system clock
  localparam int DEBOUNCE_10MS_50M = 500000;
  localparam int LONG_1S_50M       = 50000000;

  // Registered outputs of one debounced channel
  typedef struct packed {
    logic level;
    logic press;
    logic rel;
    logic hold;
  } ch_out_t;

endpackage

// File: rtl/multi_key_debounce_if.sv
// rtl/multi_key_debounce_if.sv - raw key inputs and debounced level/event outputs
interface multi_key_debounce_if #(
  parameter int CH_NUM = 4
);

  logic [CH_NUM-1:0] din;
  logic [CH_NUM-1:0] dout;
  logic [CH_NUM-1:0] press_pulse;
  logic [CH_NUM-1:0] release_pulse;
  logic [CH_NUM-1:0] long_pulse;

  // Board/pin side: drives raw inputs, consumes debounced results
  modport master (
    output din,
    input  dout,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse
  );

  // Debouncer side
  modport slave (
    input  din,
    output dout,
    output press_pulse,
    output release_pulse,
    output long_pulse
  );

endinterface

// File: rtl/multi_key_debounce_channel.sv
// rtl/multi_key_debounce_channel.sv - one channel: synchroniser, stability counter, long-press timer
module multi_key_debounce_channel
  import multi_key_debounce_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_10MS_50M,
  parameter int   LONG_CYCLES     = LONG_1S_50M,
  parameter logic IDLE_LEVEL      = 1'b1
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    din,
  output ch_out_t q
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CW-1:0]          cnt;
  logic [HW-1:0]          hcnt;
  logic                   level;
  logic                   press;
  logic                   rel;
  logic                   hold;

  assign sync = sync_q[SYNC_STAGES-1];

  // Metastability chain; starts at the released level so reset never looks like a press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  // Level follows sync only after an unbroken run of disagreement; any agreement restarts the run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= IDLE_LEVEL;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      press <= 1'b0;
      rel   <= 1'b0;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync;
        press <= (sync != IDLE_LEVEL);
        rel   <= (sync == IDLE_LEVEL);
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Hold timer runs while the debounced level is active and fires once when it saturates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
      hold <= 1'b0;
    end else begin
      hold <= (level != IDLE_LEVEL) && (hcnt == HOLD_PRE);
      if (level == IDLE_LEVEL) begin
        hcnt <= '0;
      end else if (hcnt != HOLD_MAX) begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  assign q = '{level: level, press: press, rel: rel, hold: hold};

endmodule

// File: rtl/multi_key_debounce.sv
// rtl/multi_key_debounce.sv - CH_NUM independent key debouncers behind one interface
module multi_key_debounce
  import multi_key_debounce_pkg::*;
#(
  parameter int   CH_NUM          = 4,
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_10MS_50M,
  parameter int   LONG_CYCLES     = LONG_1S_50M,
  parameter logic IDLE_LEVEL      = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  multi_key_debounce_if.slave bus
);

  ch_out_t ch_q [CH_NUM];

  // One fully independent channel per input pin
  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    multi_key_debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .IDLE_LEVEL      (IDLE_LEVEL)
    ) u_ch (
      .clk (clk),
      .rst (rst),
      .din (bus.din[i]),
      .q   (ch_q[i])
    );

    assign bus.dout[i]          = ch_q[i].level;
    assign bus.press_pulse[i]   = ch_q[i].press;
    assign bus.release_pulse[i] = ch_q[i].rel;
    assign bus.long_pulse[i]    = ch_q[i].hold;
  end

endmodule

// File: tb/tb_multi_key_debounce.sv
// tb/tb_multi_key_debounce.sv - directed and randomized checks against a windowed reference model
module tb_multi_key_debounce;

  localparam int   CH   = 4;
  localparam int   SS   = 2;
  localparam int   DC   = 8;
  localparam int   LC   = 32;
  localparam logic IDLE = 1'b1;
  localparam int   HLEN = SS + DC;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  multi_key_debounce_if #(.CH_NUM(CH)) bus ();

  multi_key_debounce #(
    .CH_NUM          (CH),
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DC),
    .LONG_CYCLES     (LC),
    .IDLE_LEVEL      (IDLE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: din samples (newest first), debounced level, edge index of the last press
  logic [CH-1:0] hist [$];
  logic [CH-1:0] dout_m;
  longint        press_t [CH];
  longint        en;
  logic [CH-1:0] exp_p, exp_r, exp_l;

  task automatic check_vec(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < HLEN; k++) hist.push_back({CH{IDLE}});
    dout_m = {CH{IDLE}};
    en     = 0;
    for (int c = 0; c < CH; c++) press_t[c] = -1000000;
  endtask

  // One clock: drive din, advance the model, compare all outputs just after the edge.
  // A channel flips when each of the last DC synchronised samples disagrees with its level;
  // the sample seen at edge n is din from SS edges earlier.
  task automatic step(input logic [CH-1:0] v);
    bit all_diff;
    bus.din = v;
    @(posedge clk);
    en++;
    hist.push_front(v);
    while (hist.size() > HLEN) void'(hist.pop_back());
    exp_p = '0;
    exp_r = '0;
    exp_l = '0;
    for (int c = 0; c < CH; c++) begin
      all_diff = 1'b1;
      for (int k = SS; k < SS + DC; k++) if (hist[k][c] == dout_m[c]) all_diff = 1'b0;
      if (dout_m[c] != IDLE && en - press_t[c] == LC) exp_l[c] = 1'b1;
      if (all_diff) begin
        dout_m[c] = ~dout_m[c];
        if (dout_m[c] != IDLE) begin
          exp_p[c]   = 1'b1;
          press_t[c] = en;
        end else begin
          exp_r[c] = 1'b1;
        end
      end
    end
    #1;
    check_vec("dout", bus.dout, dout_m);
    check_vec("press_pulse", bus.press_pulse, exp_p);
    check_vec("release_pulse", bus.release_pulse, exp_r);
    check_vec("long_pulse", bus.long_pulse, exp_l);
  endtask

  initial begin
    int            n, p0, p3, pe, le, nl;
    logic [CH-1:0] v;
    int            rem [CH];
    logic [CH-1:0] rv;

    // 1: reset with keys held active
    bus.din = 4'b0000;
    rst     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_vec("reset_dout", bus.dout, 4'b1111);
    check_vec("reset_press", bus.press_pulse, 4'b0000);
    check_vec("reset_release", bus.release_pulse, 4'b0000);
    check_vec("reset_long", bus.long_pulse, 4'b0000);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    n = -1;
    for (int i = 1; i <= 20 && n < 0; i++) begin
      step(4'b0000);
      if (bus.press_pulse == 4'b1111) n = i;
    end
    check_int("held_through_reset_press_edge", n, SS + DC);
    repeat (15) step(4'b1111);

    // 2: clean press on ch0
    n = -1;
    for (int i = 1; i <= 20 && n < 0; i++) begin
      step(4'b1110);
      if (bus.press_pulse[0]) n = i;
    end
    check_int("ch0_press_edge", n, SS + DC);
    step(4'b1110);
    check_int("ch0_press_one_cycle", int'(bus.press_pulse[0]), 0);
    repeat (15) step(4'b1111);

    // 3: bounce on ch1, then settle low
    n = 0;
    for (int i = 0; i < 40; i++) begin
      v = 4'b1111;
      v[1] = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
      step(v);
      if (bus.press_pulse[1] || bus.release_pulse[1]) n++;
    end
    check_int("ch1_bounce_no_events", n, 0);
    n = -1;
    for (int i = 1; i <= 20 && n < 0; i++) begin
      step(4'b1101);
      if (bus.press_pulse[1]) n = i;
    end
    check_int("ch1_settle_press_edge", n, SS + DC);
    repeat (15) step(4'b1111);

    // 4: long press on ch2
    pe = -1; le = -1; nl = 0;
    for (int i = 1; i <= 60; i++) begin
      step(4'b1011);
      if (bus.press_pulse[2]) pe = i;
      if (bus.long_pulse[2]) begin le = i; nl++; end
    end
    check_int("ch2_long_delay", le - pe, LC);
    check_int("ch2_long_count", nl, 1);
    n = -1;
    for (int i = 1; i <= 20 && n < 0; i++) begin
      step(4'b1111);
      if (bus.release_pulse[2]) n = i;
    end
    check_int("ch2_release_edge", n, SS + DC);
    repeat (5) step(4'b1111);

    // 5: short simultaneous press on ch0 and ch3
    p0 = -1; p3 = -1; nl = 0;
    for (int i = 1; i <= 45; i++) begin
      step(i <= 20 ? 4'b0110 : 4'b1111);
      if (bus.press_pulse[0]) p0 = i;
      if (bus.press_pulse[3]) p3 = i;
      if (bus.long_pulse[0] || bus.long_pulse[3]) nl++;
    end
    check_int("ch3_press_edge", p3, SS + DC);
    check_int("ch0_ch3_same_press", p0, p3);
    check_int("short_press_no_long", nl, 0);

    // 6: reset in the middle of a count on ch0
    repeat (SS + 5) step(4'b1110);
    #2;
    rst = 1'b1;
    #1;
    check_vec("midreset_dout", bus.dout, 4'b1111);
    check_vec("midreset_pulses", bus.press_pulse | bus.release_pulse | bus.long_pulse, 4'b0000);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    n = -1;
    for (int i = 1; i <= 20 && n < 0; i++) begin
      step(4'b1110);
      if (bus.press_pulse[0]) n = i;
    end
    check_int("midreset_restart_edge", n, SS + DC);

    // Randomized: each channel holds a random level for a random stretch
    for (int c = 0; c < CH; c++) rem[c] = 0;
    rv = 4'b1110;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < CH; c++) begin
        if (rem[c] == 0) begin
          rv[c]  = 1'($urandom_range(0, 1));
          rem[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(30, 60)) : int'($urandom_range(1, 12));
        end
        rem[c]--;
      end
      step(rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
